// File: rtl/ps2_receive_frame.sv
// rtl/ps2_receive_frame.sv - PS/2 device-to-host frame receiver with held-key tracking
//
// Purpose:
//   Synchronises and glitch-filters the raw PS/2 clock/data pins and deframes
//   11-bit device-to-host frames (start, 8 data LSB first, odd parity, stop).
//   It tracks E0 (extended) and F0 (break) prefixes, so out_data carries the
//   make code of the key currently held, or 0x00 once that key is released.
//
// Ports:
//   in_clk       system clock
//   in_reset     synchronous, active-high reset
//   in_ps2_clk   raw PS/2 clock pin (asynchronous)
//   in_ps2_data  raw PS/2 data pin (asynchronous)
//   out_data     held make code, 0x00 = none
//   out_byte     last accepted raw byte (including E0/F0)
//   out_valid    1-cycle pulse: out_byte updated this cycle
//   out_err      1-cycle pulse: parity/stop error or mid-frame timeout
module ps2_receive_frame #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int TIMEOUT_W   = 17
) (
  input  logic       in_clk,
  input  logic       in_reset,
  input  logic       in_ps2_clk,
  input  logic       in_ps2_data,
  output logic [7:0] out_data,
  output logic [7:0] out_byte,
  output logic       out_valid,
  output logic       out_err
);

  localparam int FCNT_W = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_CHECK
  } state_t;

  // Input conditioning
  logic              clk_s1;
  logic              clk_s2;
  logic              dat_s1;
  logic              dat_s2;
  logic              filt_clk;
  logic [FCNT_W-1:0] filt_cnt;
  logic              fall;

  // Deframing
  state_t                 state;
  logic [9:0]             frame;
  logic [3:0]             bitcnt;
  logic [TIMEOUT_W-1:0]   tcnt;
  logic                   brk_pend;
  logic                   ext_pend;
  logic                   frame_ok;

  // Frame layout after ten LSB-first shifts: [7:0] data, [8] parity, [9] stop.
  assign frame_ok = (^frame[8:0]) && frame[9];

  // Synchroniser and clock filter. The filtered clock only follows the synced
  // clock after FILTER_LEN consecutive disagreeing samples; any agreeing sample
  // restarts the run, so short glitches never reach the deframer.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      clk_s1 <= in_ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= in_ps2_data;
      dat_s2 <= dat_s1;
      fall   <= 1'b0;
      if (clk_s2 != filt_clk) begin
        if (filt_cnt == FCNT_W'(FILTER_LEN - 1)) begin
          filt_clk <= clk_s2;
          filt_cnt <= '0;
          // Strobe only on the 1->0 transition of the filtered clock.
          fall     <= filt_clk;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // Frame FSM with registered outputs and key tracking.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state     <= S_IDLE;
      frame     <= '0;
      bitcnt    <= '0;
      tcnt      <= '0;
      brk_pend  <= 1'b0;
      ext_pend  <= 1'b0;
      out_data  <= '0;
      out_byte  <= '0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          tcnt <= '0;
          // A high data bit on a falling edge is line noise, not a start bit.
          if (fall && !dat_s2) begin
            state  <= S_RECV;
            bitcnt <= 4'd1;
          end
        end

        S_RECV: begin
          if (fall) begin
            frame  <= {dat_s2, frame[9:1]};
            bitcnt <= bitcnt + 4'd1;
            tcnt   <= '0;
            if (bitcnt == 4'd10) begin
              state <= S_CHECK;
            end
          end else if (tcnt == TIMEOUT_W'(TIMEOUT_CYC - 1)) begin
            // Device stalled mid-frame: drop the partial frame.
            state   <= S_IDLE;
            tcnt    <= '0;
            out_err <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        S_CHECK: begin
          state <= S_IDLE;
          tcnt  <= '0;
          if (frame_ok) begin
            out_byte  <= frame[7:0];
            out_valid <= 1'b1;
            if (frame[7:0] == 8'hE0) begin
              ext_pend <= 1'b1;
            end else if (frame[7:0] == 8'hF0) begin
              brk_pend <= 1'b1;
            end else if (brk_pend) begin
              // Releasing a key other than the held one leaves the held code.
              if (frame[7:0] == out_data) begin
                out_data <= 8'h00;
              end
              brk_pend <= 1'b0;
              ext_pend <= 1'b0;
            end else begin
              // Extended keys are reported by their base code.
              out_data <= frame[7:0];
              ext_pend <= 1'b0;
            end
          end else begin
            out_err  <= 1'b1;
            brk_pend <= 1'b0;
            ext_pend <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_receive_frame.sv
// tb/tb_ps2_receive_frame.sv - scoreboard testbench for ps2_receive_frame
module tb_ps2_receive_frame;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 1500;
  localparam int TIMEOUT_W   = 11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] out_data;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_err;

  ps2_receive_frame #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TIMEOUT_W  (TIMEOUT_W)
  ) dut (
    .in_clk     (clk),
    .in_reset   (rst),
    .in_ps2_clk (ps2_clk),
    .in_ps2_data(ps2_data),
    .out_data   (out_data),
    .out_byte   (out_byte),
    .out_valid  (out_valid),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] bval;
    logic [7:0] dval;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_err_cyc = -1;
  int   t_fall = 0;

  // Reference key-tracking state
  logic [7:0] m_data = 8'h00;
  bit         m_brk = 1'b0;
  bit         m_ext = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every output event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (out_valid || out_err)) begin
      exp_t e;
      check("valid_err_exclusive", int'(out_valid && out_err), 0);
      if (out_err) last_err_cyc = cyc;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: valid=%0b err=%0b byte=0x%0h, none expected",
                 out_valid, out_err, out_byte);
      end else begin
        e = exp_q.pop_front();
        check("event_is_err", int'(out_err), int'(e.is_err));
        if (!e.is_err) check("out_byte", int'(out_byte), int'(e.bval));
        check("out_data", int'(out_data), int'(e.dval));
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives the first nbits of an 11-bit frame, bit 0 first. A low glitch of
  // FILTER_LEN-2 cycles is inserted in the high phase before bit glitch_bit.
  task automatic drive_bits(input logic [10:0] bits, input int nbits, input int h,
                            input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        wait_cyc(h / 2);
        ps2_clk = 1'b0;
        wait_cyc(FILTER_LEN - 2);
        ps2_clk = 1'b1;
        wait_cyc(h - h / 2);
      end else begin
        wait_cyc(h);
      end
      ps2_clk = 1'b0;
      t_fall = cyc;
      wait_cyc(h);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  // Model of one complete frame: expected outcome computed from the protocol rules.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int h, input int glitch_bit);
    logic       par;
    logic       stp;
    exp_t       e;
    par = ~(^b) ^ bad_par;
    stp = ~bad_stop;
    if (!bad_par && !bad_stop) begin
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else if (m_brk) begin
        if (b == m_data) m_data = 8'h00;
        m_brk = 1'b0;
        m_ext = 1'b0;
      end else begin
        m_data = b;
        m_ext = 1'b0;
      end
      e.is_err = 1'b0;
    end else begin
      m_brk = 1'b0;
      m_ext = 1'b0;
      e.is_err = 1'b1;
    end
    e.bval = b;
    e.dval = m_data;
    exp_q.push_back(e);
    drive_bits({stp, par, b, 1'b0}, 11, h, glitch_bit);
    wait_cyc(4 * h + 30);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 25, -1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pick [8];
    exp_t       e;
    pick[0] = 8'h1C; pick[1] = 8'h1B; pick[2] = 8'h23; pick[3] = 8'h4D;
    pick[4] = 8'hF0; pick[5] = 8'hE0; pick[6] = 8'h1D; pick[7] = 8'h75;

    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(3);
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_byte", int'(out_byte), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_err", int'(out_err), 0);

    // Make, break, break of a different key, extended make
    good(8'h1C);
    good(8'hF0);
    good(8'h1C);
    good(8'h1C);
    good(8'hF0);
    good(8'h1B);
    good(8'hE0);
    good(8'h1D);

    // Parity error, then stop error
    send_frame(8'h1D, 1'b1, 1'b0, 25, -1);
    send_frame(8'h1D, 1'b0, 1'b1, 25, -1);

    // Timeout after 5 bits
    e.is_err = 1'b1;
    e.bval = 8'h00;
    e.dval = m_data;
    exp_q.push_back(e);
    last_err_cyc = -1;
    drive_bits(11'b000_1010_1010, 5, 25, -1);
    wait_cyc(TIMEOUT_CYC + 200);
    tests++;
    if (last_err_cyc < t_fall + TIMEOUT_CYC ||
        last_err_cyc > t_fall + TIMEOUT_CYC + FILTER_LEN + 12) begin
      fails++;
      $display("FAIL timeout_latency: got %0d cycles expected about %0d",
               last_err_cyc - t_fall, TIMEOUT_CYC);
    end
    good(8'h23);

    // Glitch inside a frame must not shift a bit
    send_frame(8'h35, 1'b0, 1'b0, 25, 3);

    // Reset mid-frame
    drive_bits(11'b110_0100_1100, 4, 25, -1);
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    m_data = 8'h00;
    m_brk = 1'b0;
    m_ext = 1'b0;
    wait_cyc(60);
    check("midframe_reset_out_data", int'(out_data), 0);
    check("midframe_reset_out_byte", int'(out_byte), 0);
    good(8'h4D);

    // Randomised traffic
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      int         r;
      b = pick[$urandom_range(0, 7)];
      r = $urandom_range(0, 9);
      send_frame(b, r == 0, r == 1, $urandom_range(20, 40), -1);
    end

    wait_cyc(50);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
